// File: rtl/div_bcd_formatter_pkg.sv
// Shared types and helpers for the divider BCD formatter: FSM state encoding,
// the blank-digit code and the minimum-digit-count function used to validate DIGITS.
package div_pkg;

    typedef enum logic [1:0] {IDLE, CONV_Q, CONV_R, DONE} bcd_state_t;

    localparam logic [3:0] BCD_BLANK = 4'hF;

    // Number of decimal digits needed to print 2^w-1.
    function automatic int bcd_digits(input int w);
        longint unsigned v;
        int              n;
        v = (64'd1 << w) - 64'd1;
        n = 1;
        while (v >= 64'd10) begin
            v = v / 64'd10;
            n = n + 1;
        end
        return n;
    endfunction

endpackage

// File: rtl/div_bcd_formatter_bcd_add3.sv
// One double-dabble digit correction: adds 3 to a BCD digit of 5 or more so the
// following left shift carries correctly into the next decimal digit.
module bcd_add3 (
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);

    assign digit_o = (digit_i >= 4'd5) ? digit_i + 4'd3 : digit_i;

endmodule

// File: rtl/div_bcd_formatter.sv
// Sequential binary-to-BCD formatter for the divider's {quotient, remainder} result,
// one shared double-dabble engine; define DIV_BCD_BLANK_EN for leading-zero blanking.
module div_bcd_formatter
    import div_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      quotient,
    input  logic [WIDTH-1:0]      remainder,
    input  logic                  src_valid,
    output logic                  src_ready,
    output logic                  dest_valid,
    input  logic                  dest_ready,
    output logic [4*DIGITS-1:0]   quotient_bcd,
    output logic [4*DIGITS-1:0]   remainder_bcd
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);
    localparam int SW = BW + WIDTH;

    if (DIGITS < bcd_digits(WIDTH)) begin : g_digits_check
        $error("div_bcd_formatter: DIGITS=%0d too small for WIDTH=%0d", DIGITS, WIDTH);
    end

    bcd_state_t         state_q,    state_d;
    logic [CW-1:0]      cnt_q,      cnt_d;
    logic [SW-1:0]      scratch_q,  scratch_d;
    logic [WIDTH-1:0]   rem_hold_q, rem_hold_d;
    logic [BW-1:0]      qbcd_q,     qbcd_d;
    logic [BW-1:0]      rbcd_q,     rbcd_d;

    logic [BW-1:0]      bcd_adj;
    logic [SW-1:0]      adj_val;
    logic [SW-1:0]      step_val;
    logic               last_step;

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_add3
        bcd_add3 u_add3 (
            .digit_i (scratch_q[WIDTH + 4*gi +: 4]),
            .digit_o (bcd_adj[4*gi +: 4])
        );
    end

    assign adj_val   = {bcd_adj, scratch_q[WIDTH-1:0]};
    assign step_val  = adj_val << 1;
    assign last_step = (cnt_q == CW'(WIDTH - 1));

`ifdef DIV_BCD_BLANK_EN
    // Digits above the most significant non-zero digit become blanks; digit 0 always shows.
    function automatic logic [BW-1:0] fmt_result(input logic [BW-1:0] bcd);
        logic [BW-1:0] res;
        logic          lead;
        res  = bcd;
        lead = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (lead && (bcd[4*i +: 4] == 4'd0)) begin
                res[4*i +: 4] = BCD_BLANK;
            end else begin
                lead = 1'b0;
            end
        end
        return res;
    endfunction
`else
    function automatic logic [BW-1:0] fmt_result(input logic [BW-1:0] bcd);
        return bcd;
    endfunction
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        scratch_d  = scratch_q;
        rem_hold_d = rem_hold_q;
        qbcd_d     = qbcd_q;
        rbcd_d     = rbcd_q;
        case (state_q)
            IDLE: begin
                if (src_valid) begin
                    scratch_d  = {{BW{1'b0}}, quotient};
                    rem_hold_d = remainder;
                    cnt_d      = '0;
                    state_d    = CONV_Q;
                end
            end
            CONV_Q: begin
                scratch_d = step_val;
                cnt_d     = cnt_q + CW'(1);
                if (last_step) begin
                    qbcd_d    = fmt_result(step_val[SW-1:WIDTH]);
                    scratch_d = {{BW{1'b0}}, rem_hold_q};
                    cnt_d     = '0;
                    state_d   = CONV_R;
                end
            end
            CONV_R: begin
                scratch_d = step_val;
                cnt_d     = cnt_q + CW'(1);
                if (last_step) begin
                    rbcd_d  = fmt_result(step_val[SW-1:WIDTH]);
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (dest_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            scratch_q  <= '0;
            rem_hold_q <= '0;
            qbcd_q     <= '0;
            rbcd_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            scratch_q  <= scratch_d;
            rem_hold_q <= rem_hold_d;
            qbcd_q     <= qbcd_d;
            rbcd_q     <= rbcd_d;
        end
    end

    assign src_ready     = (state_q == IDLE);
    assign dest_valid    = (state_q == DONE);
    assign quotient_bcd  = qbcd_q;
    assign remainder_bcd = rbcd_q;

endmodule

// File: tb/tb_div_bcd_formatter.sv
// Randomized self-checking bench for div_bcd_formatter against a decimal reference model.
module tb_div_bcd_formatter;

    localparam int WIDTH  = 16;
    localparam int DIGITS = 5;
    localparam int BW     = 4 * DIGITS;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [WIDTH-1:0]  quotient = '0;
    logic [WIDTH-1:0]  remainder = '0;
    logic              src_valid = 1'b0;
    logic              src_ready;
    logic              dest_valid;
    logic              dest_ready = 1'b0;
    logic [BW-1:0]     quotient_bcd;
    logic [BW-1:0]     remainder_bcd;

    int                checks = 0;
    int                errors = 0;
    int                txn_no = 0;
    logic [BW-1:0]     prev_q = '0;
    logic [BW-1:0]     prev_r = '0;

    always #5 clk = ~clk;

    div_bcd_formatter #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk           (clk),
        .rst           (rst),
        .quotient      (quotient),
        .remainder     (remainder),
        .src_valid     (src_valid),
        .src_ready     (src_ready),
        .dest_valid    (dest_valid),
        .dest_ready    (dest_ready),
        .quotient_bcd  (quotient_bcd),
        .remainder_bcd (remainder_bcd)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Decimal digits by repeated division; leading digits optionally blanked.
    function automatic logic [BW-1:0] ref_bcd(input int unsigned v);
        logic [BW-1:0] res;
        int unsigned   t;
        int            n;
        res = '0;
        t   = v;
        for (int i = 0; i < DIGITS; i++) begin
            res[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
`ifdef DIV_BCD_BLANK_EN
        n = 1;
        t = v;
        while (t >= 10) begin
            t = t / 10;
            n++;
        end
        for (int i = n; i < DIGITS; i++) res[4*i +: 4] = 4'hF;
`else
        n = 0;
`endif
        return res;
    endfunction

    task automatic run_txn(input logic [WIDTH-1:0] q, input logic [WIDTH-1:0] r,
                           input int src_dly, input int dest_dly, input bit bp_probe);
        logic [BW-1:0] eq;
        logic [BW-1:0] er;
        int            edges;
        bit            acc;
        eq  = ref_bcd(q);
        er  = ref_bcd(r);
        acc = 1'b0;
        repeat (src_dly) @(posedge clk);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (i == 0) begin
                src_valid = 1'b1;
                quotient  = q;
                remainder = r;
            end
            acc = src_ready;
            @(posedge clk);
            if (acc) break;
        end
        if (!acc) check_eq("accept_timeout", 64'(acc), 64'd1);
        #1;
        src_valid = 1'b0;
        quotient  = WIDTH'($urandom);
        remainder = WIDTH'($urandom);
        edges = 0;
        while (edges < 200) begin
            @(posedge clk);
            edges++;
            #1;
            if (edges == WIDTH / 2) begin
                check_eq("hold_prev_q", 64'(quotient_bcd), 64'(prev_q));
                check_eq("busy_src_ready", 64'(src_ready), 64'd0);
            end
            if (dest_valid) break;
        end
        check_eq("latency", 64'(edges), 64'(2 * WIDTH));
        check_eq("quotient_bcd", 64'(quotient_bcd), 64'(eq));
        check_eq("remainder_bcd", 64'(remainder_bcd), 64'(er));
        for (int i = 0; i < dest_dly; i++) begin
            @(negedge clk);
            if (bp_probe) begin
                src_valid = (i == 3);
                quotient  = 16'd7777;
                remainder = 16'd8888;
            end
            check_eq("bp_dest_valid", 64'(dest_valid), 64'd1);
            check_eq("bp_src_ready", 64'(src_ready), 64'd0);
            check_eq("bp_quotient", 64'(quotient_bcd), 64'(eq));
            check_eq("bp_remainder", 64'(remainder_bcd), 64'(er));
        end
        @(negedge clk);
        src_valid  = 1'b0;
        dest_ready = 1'b1;
        @(posedge clk);
        #1;
        dest_ready = 1'b0;
        check_eq("release_src_ready", 64'(src_ready), 64'd1);
        check_eq("release_dest_valid", 64'(dest_valid), 64'd0);
        check_eq("idle_keep_q", 64'(quotient_bcd), 64'(eq));
        check_eq("idle_keep_r", 64'(remainder_bcd), 64'(er));
        prev_q = eq;
        prev_r = er;
        txn_no++;
        $display("txn %0d q=%0d r=%0d quotient_bcd=%h remainder_bcd=%h lat=%0d",
                 txn_no, q, r, quotient_bcd, remainder_bcd, edges);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog simulation did not finish got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH-1:0] dvd;
        logic [WIDTH-1:0] dvs;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("reset_src_ready", 64'(src_ready), 64'd1);
        check_eq("reset_dest_valid", 64'(dest_valid), 64'd0);
        check_eq("reset_quotient", 64'(quotient_bcd), 64'd0);
        check_eq("reset_remainder", 64'(remainder_bcd), 64'd0);

        run_txn(16'd65535, 16'd0, 0, 0, 1'b0);
        run_txn(16'd12345, 16'd9, 1, 2, 1'b0);
        run_txn(16'd0, 16'd0, 0, 0, 1'b0);
        run_txn(16'd50505, 16'd999, 2, 10, 1'b1);

        // Reset in the middle of the quotient conversion.
        @(negedge clk);
        src_valid = 1'b1;
        quotient  = 16'd1111;
        remainder = 16'd2222;
        @(posedge clk);
        #1;
        src_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("midrst_src_ready", 64'(src_ready), 64'd1);
        check_eq("midrst_dest_valid", 64'(dest_valid), 64'd0);
        check_eq("midrst_quotient", 64'(quotient_bcd), 64'd0);
        check_eq("midrst_remainder", 64'(remainder_bcd), 64'd0);
        prev_q = '0;
        prev_r = '0;
        run_txn(16'd4321, 16'd17, 0, 0, 1'b0);

        for (int n = 0; n < 500; n++) begin
            dvd = WIDTH'($urandom);
            if ($urandom_range(0, 3) == 0) dvs = WIDTH'($urandom_range(1, 20));
            else                           dvs = WIDTH'($urandom_range(1, 65535));
            run_txn(dvd / dvs, dvd % dvs, $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
